// File: rtl/bit_unpacker.sv
// Variable-length field extractor: buffers 64-bit packed words LSB-first and
// hands out 1..64-bit fields on request, oldest bits first.
module bit_unpacker (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  req_bits,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        msg_fin,
  output logic [63:0] data_out,
  output logic        out_valid,
  output logic        err,
  output logic [7:0]  bit_count
);

  logic [127:0] buf_q, buf_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [63:0]  data_out_q, data_out_d;
  logic         out_valid_q, out_valid_d;
  logic         err_q, err_d;

  logic         req_legal;
  logic         load;
  logic         extract;
  logic         illegal;
  logic [7:0]   k;
  logic [63:0]  field_mask;
  logic [127:0] word_ins;

  assign req_legal = (req_bits != 7'd0) && (req_bits <= 7'd64);
  assign in_ready  = !msg_fin && (cnt_q <= 8'd64);
  assign req_ready = !msg_fin && (!req_legal || (cnt_q >= {1'b0, req_bits}));

  assign load    = in_valid && in_ready;
  assign extract = req_valid && req_ready && req_legal;
  assign illegal = req_valid && req_ready && !req_legal;

  always_comb begin
    k           = extract ? {1'b0, req_bits} : 8'd0;
    // k is at least 1 whenever the mask is used, so the shift stays within 0..63
    field_mask  = {64{1'b1}} >> (8'd64 - k);
    // New word lands just above the bits that survive this cycle's extract
    word_ins    = {64'd0, data_in} << (cnt_q - k);

    buf_d       = (buf_q >> k) | (load ? word_ins : 128'd0);
    cnt_d       = cnt_q - k + (load ? 8'd64 : 8'd0);
    data_out_d  = extract ? (buf_q[63:0] & field_mask) : data_out_q;
    out_valid_d = extract;
    err_d       = illegal;

    if (msg_fin) begin
      buf_d       = 128'd0;
      cnt_d       = 8'd0;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q       <= 128'd0;
      cnt_q       <= 8'd0;
      data_out_q  <= 64'd0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign bit_count = cnt_q;

endmodule

// File: tb/tb_bit_unpacker.sv
// Bench for bit_unpacker: a bit-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bit_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data_in = 64'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  req_bits = 7'd1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        msg_fin = 1'b0;
  logic [63:0] data_out;
  logic        out_valid;
  logic        err;
  logic [7:0]  bit_count;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] W1 = 64'h0123456789ABCDEF;

  bit_unpacker dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .req_bits(req_bits), .req_valid(req_valid),
    .req_ready(req_ready), .msg_fin(msg_fin), .data_out(data_out),
    .out_valid(out_valid), .err(err), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  // Reference model: buffered bits as a FIFO of single bits, oldest at front
  bit          mq[$];
  logic [63:0] m_dout = 64'd0;
  logic        m_ov = 1'b0;
  logic        m_err = 1'b0;
  logic [63:0] m_v;
  bit          m_ir, m_rr;

  function automatic bit legal(logic [6:0] r);
    return (r >= 7'd1) && (r <= 7'd64);
  endfunction

  function automatic bit m_in_ready();
    return !msg_fin && (mq.size() <= 64);
  endfunction

  function automatic bit m_req_ready();
    return !msg_fin && (!legal(req_bits) || (mq.size() >= int'(req_bits)));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_dout = 64'd0;
      m_ov   = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_ir  = m_in_ready();
      m_rr  = m_req_ready();
      m_ov  = 1'b0;
      m_err = 1'b0;
      if (msg_fin) begin
        mq.delete();
      end else begin
        if (req_valid && m_rr && legal(req_bits)) begin
          m_v = 64'd0;
          for (int i = 0; i < int'(req_bits); i++) m_v[i] = mq.pop_front();
          m_dout = m_v;
          m_ov   = 1'b1;
        end else if (req_valid && m_rr) begin
          m_err = 1'b1;
        end
        if (in_valid && m_ir)
          for (int i = 0; i < 64; i++) mq.push_back(data_in[i]);
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_data_out",  {64'd0, data_out},  {64'd0, m_dout});
      chk("model_out_valid", {127'd0, out_valid}, {127'd0, m_ov});
      chk("model_err",       {127'd0, err},       {127'd0, m_err});
      chk("model_bit_count", {120'd0, bit_count}, 128'(mq.size()));
      chk("model_in_ready",  {127'd0, in_ready},  {127'd0, m_in_ready()});
      chk("model_req_ready", {127'd0, req_ready}, {127'd0, m_req_ready()});
    end
  end

  task automatic cyc(input logic iv, input logic [63:0] d, input logic rv,
                     input logic [6:0] rb, input logic f);
    in_valid = iv; data_in = d; req_valid = rv; req_bits = rb; msg_fin = f;
    @(posedge clk); #1;
    in_valid = 1'b0; req_valid = 1'b0; req_bits = 7'd1; msg_fin = 1'b0;
  endtask

  initial begin
    logic [6:0] rb;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single-word split
    cyc(1, W1, 0, 7'd1, 0);
    cyc(0, 0, 1, 7'd4, 0);
    chk("split4", {64'd0, data_out}, 128'h0F);
    chk("split4_ov", {127'd0, out_valid}, 128'd1);
    cyc(0, 0, 1, 7'd8, 0);
    chk("split8", {64'd0, data_out}, 128'hDE);
    cyc(0, 0, 1, 7'd52, 0);
    chk("split52", {64'd0, data_out}, 128'h0123456789ABC);
    chk("split_cnt", {120'd0, bit_count}, 128'd0);
    cyc(0, 0, 0, 7'd1, 0);
    chk("split_ov_end", {127'd0, out_valid}, 128'd0);

    // Word-crossing field
    cyc(1, W1, 0, 7'd1, 0);
    cyc(0, 0, 1, 7'd4, 0);
    cyc(1, 64'hFFFFFFFFFFFFFFFF, 0, 7'd1, 0);
    cyc(0, 0, 1, 7'd64, 0);
    chk("cross64", {64'd0, data_out}, 128'hF0123456789ABCDE);
    chk("cross_cnt", {120'd0, bit_count}, 128'd60);
    cyc(0, 0, 0, 7'd1, 1);

    // Backpressure
    cyc(1, W1, 0, 7'd1, 0);
    cyc(1, 64'h1111111111111111, 0, 7'd1, 0);
    chk("full_cnt", {120'd0, bit_count}, 128'd128);
    chk("full_in_ready", {127'd0, in_ready}, 128'd0);
    cyc(0, 0, 1, 7'd64, 0);
    chk("drain_in_ready", {127'd0, in_ready}, 128'd1);
    chk("drain_data", {64'd0, data_out}, {64'd0, W1});
    cyc(0, 0, 0, 7'd1, 1);

    // Stall on empty
    req_valid = 1'b1; req_bits = 7'd1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("empty_req_ready", {127'd0, req_ready}, 128'd0);
      @(posedge clk); #1;
      chk("empty_ov", {127'd0, out_valid}, 128'd0);
    end
    cyc(1, W1, 1, 7'd1, 0);
    chk("stall_ov", {127'd0, out_valid}, 128'd0);
    chk("stall_cnt", {120'd0, bit_count}, 128'd64);
    cyc(0, 0, 1, 7'd1, 0);
    chk("stall_release", {64'd0, data_out}, 128'd1);
    cyc(0, 0, 0, 7'd1, 1);

    // Simultaneous load and extract
    cyc(1, W1, 0, 7'd1, 0);
    cyc(1, 64'hAAAAAAAAAAAAAAAA, 1, 7'd64, 0);
    chk("sim_old", {64'd0, data_out}, {64'd0, W1});
    chk("sim_cnt", {120'd0, bit_count}, 128'd64);
    cyc(0, 0, 1, 7'd64, 0);
    chk("sim_new", {64'd0, data_out}, 128'hAAAAAAAAAAAAAAAA);

    // Flush with pending word, then illegal lengths
    cyc(1, W1, 0, 7'd1, 0);
    cyc(0, 0, 1, 7'd27, 0);
    chk("pre_flush_cnt", {120'd0, bit_count}, 128'd37);
    cyc(1, 64'h5555555555555555, 1, 7'd1, 1);
    chk("flush_cnt", {120'd0, bit_count}, 128'd0);
    chk("flush_ov", {127'd0, out_valid}, 128'd0);
    cyc(1, W1, 0, 7'd1, 0);
    cyc(0, 0, 1, 7'd0, 0);
    chk("ill0_err", {127'd0, err}, 128'd1);
    chk("ill0_cnt", {120'd0, bit_count}, 128'd64);
    cyc(0, 0, 0, 7'd1, 0);
    chk("ill0_once", {127'd0, err}, 128'd0);
    cyc(0, 0, 1, 7'd65, 0);
    chk("ill65_err", {127'd0, err}, 128'd1);
    chk("ill65_ov", {127'd0, out_valid}, 128'd0);

    // Asynchronous reset mid-cycle while holding state and a fresh output
    cyc(0, 0, 1, 7'd4, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_data_out", {64'd0, data_out}, 128'd0);
    chk("rst_ov", {127'd0, out_valid}, 128'd0);
    chk("rst_cnt", {120'd0, bit_count}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_req_ready", {127'd0, req_ready}, 128'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 15) == 0)
        rb = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom_range(65, 127));
      else if ($urandom_range(0, 3) == 0)
        rb = 7'd64;
      else
        rb = 7'($urandom_range(1, 64));
      cyc($urandom_range(0, 2) != 0, {$urandom, $urandom}, $urandom_range(0, 1) == 1,
          rb, $urandom_range(0, 99) == 0);
    end
    repeat (2) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
